// File: rtl/frame_bank_pkg.sv
// frame_bank_pkg: shared bank count, bank index type and write-FSM states.
package frame_bank_pkg;
   localparam int NUM_BANK = 4;
   localparam int BANK_W = 2;
   typedef logic [BANK_W-1:0] bank_t;
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_ACTIVE} wstate_t;
endpackage

// File: rtl/frame_bank_alloc.sv
// frame_bank_alloc: combinational picker of the lowest bank the writer may use.
// Ports: rd_bank (bank being read), latest/latest_vld (newest completed bank), bank (chosen free bank).
module frame_bank_alloc
   import frame_bank_pkg::*;
(
   input  bank_t rd_bank,
   input  bank_t latest,
   input  logic  latest_vld,
   output bank_t bank
);
   // Walk from the top down so the last hit is the lowest free index.
   always_comb begin
      bank = '0;
      for (int i = NUM_BANK - 1; i >= 0; i--)
         if (BANK_W'(i) != rd_bank && !(latest_vld && BANK_W'(i) == latest)) bank = BANK_W'(i);
   end
endmodule

// File: rtl/frame_bank_sched.sv
// frame_bank_sched: four-bank frame buffer scheduler between one writer and one reader.
// Ports: pclk/rst (sync active-high), writer handshake wr_frame_req/ack/done with wr_bank/wr_base,
// reader handshake rd_frame_req/ack with rd_bank/rd_base, status rd_valid, wr_busy, drop_cnt.
module frame_bank_sched
   import frame_bank_pkg::*;
#(
   parameter int                ADDR_W    = 24,
   parameter logic [ADDR_W-1:0] BANK_SIZE = 24'h080000
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              wr_frame_req,
   output logic              wr_frame_ack,
   input  logic              wr_frame_done,
   output logic [1:0]        wr_bank,
   output logic [ADDR_W-1:0] wr_base,
   input  logic              rd_frame_req,
   output logic              rd_frame_ack,
   output logic [1:0]        rd_bank,
   output logic [ADDR_W-1:0] rd_base,
   output logic              rd_valid,
   output logic              wr_busy,
   output logic [15:0]       drop_cnt
);
   wstate_t r_state, w_next;
   bank_t   r_latest, w_alloc;
   logic    r_latest_vld, r_fresh, r_regrant;
   logic    w_grant, w_commit, w_abort, w_drop;

   frame_bank_alloc u_alloc (
      .rd_bank   (rd_bank),
      .latest    (r_latest),
      .latest_vld(r_latest_vld),
      .bank      (w_alloc)
   );

   always_ff @(posedge pclk)
      if (rst) r_state <= W_IDLE;
      else     r_state <= w_next;

   // A commit that coincides with a read is not a drop: the read consumed the old frame.
   always_comb begin
      w_grant  = r_state == W_ACK;
      w_commit = r_state == W_ACTIVE && wr_frame_done;
      w_abort  = r_state == W_ACTIVE && wr_frame_req && !wr_frame_done;
      w_drop   = w_abort || (w_commit && r_fresh && !rd_frame_req);
      wr_busy  = r_state == W_ACTIVE;
      rd_valid = r_latest_vld;
      w_next   = r_state == W_IDLE ? (wr_frame_req ? W_ACK : W_IDLE) :
                 w_grant          ? W_ACTIVE :
                 wr_frame_req     ? W_ACK :
                 wr_frame_done    ? W_IDLE : W_ACTIVE;
   end

   always_ff @(posedge pclk)
      if (rst) begin
         wr_frame_ack <= 1'b0;
         rd_frame_ack <= 1'b0;
         wr_bank      <= '0;
         wr_base      <= '0;
         rd_bank      <= '0;
         rd_base      <= '0;
         r_latest     <= '0;
         r_latest_vld <= 1'b0;
         r_fresh      <= 1'b0;
         r_regrant    <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         wr_frame_ack <= w_grant;
         rd_frame_ack <= rd_frame_req;
         // An aborted frame is re-granted the bank it already holds.
         r_regrant    <= w_abort;
         if (w_grant && !r_regrant) begin
            wr_bank <= w_alloc;
            wr_base <= ADDR_W'(w_alloc) * BANK_SIZE;
         end
         if (rd_frame_req && r_fresh) begin
            rd_bank <= r_latest;
            rd_base <= ADDR_W'(r_latest) * BANK_SIZE;
         end
         if (w_commit) begin
            r_latest     <= wr_bank;
            r_latest_vld <= 1'b1;
         end
         r_fresh <= w_commit ? 1'b1 : rd_frame_req ? 1'b0 : r_fresh;
         if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
endmodule

// File: doc/frame_bank_sched.md
FRAME_BANK_SCHED -- requirements
Module: frame_bank_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, width of the frame base addresses.
REQ-002 SHALL have parameter BANK_SIZE, default 24'h080000, address span of one frame bank.
REQ-003 SHALL have port pclk  in  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_frame_req  in  1  writer frame-start request, level, held until acked.
REQ-006 SHALL have port wr_frame_ack  out  1  one-cycle pulse granting a write bank.
REQ-007 SHALL have port wr_frame_done  in  1  one-cycle pulse, current write frame complete.
REQ-008 SHALL have port wr_bank  out  2  bank index being written.
REQ-009 SHALL have port wr_base  out  ADDR_W  equal to wr_bank*BANK_SIZE.
REQ-010 SHALL have port rd_frame_req  in  1  one-cycle pulse at reader frame start.
REQ-011 SHALL have port rd_frame_ack  out  1  one-cycle pulse, rd_bank updated.
REQ-012 SHALL have port rd_bank  out  2  bank index to read; rd_base  out  ADDR_W  equal to rd_bank*BANK_SIZE.
REQ-013 SHALL have port rd_valid  out  1  high once any frame has completed.
REQ-014 SHALL have port wr_busy  out  1  high in W_ACTIVE; drop_cnt  out  16  count of lost frames.

Function
REQ-015 Four banks SHALL be used, indices 0-3.
REQ-016 Internal state SHALL be: latest (2b, last completed bank), latest_vld, and fresh (latest not yet handed to the reader).
REQ-017 The write FSM SHALL have states W_IDLE, W_ACK and W_ACTIVE.
REQ-018 W_IDLE SHALL go to W_ACK when wr_frame_req=1.
REQ-019 W_ACK SHALL pulse wr_frame_ack for one cycle, load wr_bank with the allocated bank, then go to W_ACTIVE.
REQ-020 W_ACTIVE SHALL go to W_IDLE on wr_frame_done.
REQ-021 Allocation SHALL pick the lowest index not equal to rd_bank and not equal to latest when latest_vld=1, using the register values of the W_ACK cycle; a free bank always exists.
REQ-022 A commit (wr_frame_done in W_ACTIVE) SHALL set latest<=wr_bank, latest_vld<=1 and fresh<=1.
REQ-023 If fresh was already 1 at a commit, drop_cnt SHALL increment, since an unread frame is overwritten.
REQ-024 wr_frame_req in W_ACTIVE without wr_frame_done SHALL abort the frame: drop_cnt increments, the state goes to W_ACK, and wr_bank is re-granted unchanged.
REQ-025 wr_frame_done and wr_frame_req in the same W_ACTIVE cycle SHALL commit first, then go to W_ACK, with no drop for the abort.
REQ-026 wr_frame_done outside W_ACTIVE SHALL be ignored.
REQ-027 rd_frame_req SHALL produce rd_frame_ack on the next cycle, with rd_bank updated in the same cycle as the ack.
REQ-028 On that update, if fresh=1 then rd_bank<=latest and fresh<=0; otherwise rd_bank holds, so the same frame repeats.
REQ-029 When rd_frame_req coincides with a commit, the read SHALL use the pre-commit latest/fresh values; the commit then sets fresh=1 and counts no drop.
REQ-030 drop_cnt SHALL saturate at 16'hFFFF.
REQ-031 wr_base and rd_base SHALL be registered and change in the same cycle as their bank index.

Reset
REQ-032 While rst=1 at pclk, the state SHALL be W_IDLE and wr_bank, rd_bank, latest, latest_vld, fresh, drop_cnt, wr_base, rd_base, both acks, wr_busy and rd_valid SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame with no commit and no drop count.

Structure
REQ-034 Package frame_bank_pkg SHALL hold the NUM_BANK=4 constant, the bank-index width and the write-state enum.
REQ-035 Sub-module frame_bank_alloc SHALL be the combinational lowest-free-bank picker (inputs rd_bank, latest, latest_vld; output bank).

Verification
REQ-036 After reset, wr_frame_req=1 SHALL give wr_frame_ack 2 cycles later, wr_bank=1 and wr_base=24'h080000.
REQ-037 A done pulse, then rd_frame_req, SHALL give rd_frame_ack next cycle with rd_bank=1, rd_valid=1 and fresh=0; the next write SHALL then be granted bank 0.
REQ-038 Two commits with no read between SHALL give drop_cnt=1, and the next read SHALL get the second bank.
REQ-039 wr_frame_req twice in W_ACTIVE without done SHALL give drop_cnt=1 and the same wr_bank re-acked.
REQ-040 rd_frame_req coinciding with a commit SHALL give a read of the old latest, fresh=1 afterwards and drop_cnt unchanged.
REQ-041 rst in W_ACTIVE followed by a read SHALL give rd_valid=0 and rd_bank=0.
